retospect_cfg_loader: RTL and testbench
=======================================

RETOSPECT_CFG_LOADER -- requirements
Module: retospect_cfg_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 523, meaning total configuration-chain bits (clockbox 48 + 25 cells x 19).
REQ-002 SHALL have parameter CNT_W, default 10, meaning bit-counter width; CNT_W SHALL satisfy 2**CNT_W > CHAIN_LEN.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  one-cycle request to begin a load; honoured only in IDLE.
REQ-006 SHALL have port abort  in  1  terminate the current load.
REQ-007 SHALL have ports in_data / in_valid / in_ready  8/1/1  config byte stream; in_data and in_valid are inputs, in_ready is an output.
REQ-008 SHALL have ports rd_data / rd_valid / rd_ready  8/1/1  readback byte stream; rd_data and rd_valid are outputs, rd_ready is an input.
REQ-009 SHALL have port cfg_en  out  1  drives chain config_en.
REQ-010 SHALL have port cfg_bs  out  1  drives chain bs_in.
REQ-011 SHALL have port cfg_ret  in  1  chain bs_out return.
REQ-012 SHALL have ports busy / done  out  1/1  load in progress / one-cycle completion pulse.

Function
REQ-013 FSM states SHALL be IDLE, FETCH, SHIFT, DRAIN, DONE.
REQ-014 IDLE: start=1 -> FETCH; bit counter cleared to 0.
REQ-015 FETCH: in_ready=1; on in_valid&in_ready, latch the byte into the shift register -> SHIFT.
REQ-016 SHIFT: each cycle with no stall, cfg_en=1, cfg_bs=shreg[0], shreg shifts right, bit counter +1.
REQ-017 Bits SHALL be sent LSB-first.
REQ-018 After 8 bits of a byte, or when bit counter reaches CHAIN_LEN: go to FETCH if bits remain, else DRAIN.
REQ-019 Final byte SHALL use only CHAIN_LEN mod 8 LSBs (all 8 if the remainder is 0); its upper bits SHALL be ignored and never driven.
REQ-020 Readback: on every cycle where cfg_en=1, cfg_ret SHALL be sampled into rd shreg LSB-first (the bit leaving the chain on that edge).
REQ-021 After 8 sampled bits, rd_data/rd_valid SHALL assert on the next cycle and hold until rd_valid&rd_ready.
REQ-022 If rd_valid=1 and another 8 bits would complete, SHIFT SHALL stall: cfg_en=0, counters hold, until the handshake.
REQ-023 No readback bit SHALL ever be lost.
REQ-024 DRAIN: a partial final readback byte SHALL be zero-padded in the upper bits and presented.
REQ-025 DRAIN SHALL exit to DONE once rd_valid is clear.
REQ-026 DONE: done=1 for exactly one cycle -> IDLE.
REQ-027 busy=1 in every state except IDLE.
REQ-028 cfg_en SHALL be 1 only in SHIFT non-stall cycles; exactly CHAIN_LEN cfg_en cycles per completed load.
REQ-029 abort=1 in any non-IDLE state -> IDLE next cycle.
REQ-030 On abort, cfg_en SHALL drop the same cycle (combinational gate), pending rd_valid SHALL clear, and done SHALL NOT pulse.
REQ-031 start SHALL be ignored while busy; abort SHALL have priority over start.
REQ-032 Counter arithmetic SHALL be unsigned CNT_W bits, no wrap within a load.

Reset
REQ-033 While rst_n=0: state=IDLE, cfg_en=0, cfg_bs=0, in_ready=0, rd_valid=0, rd_data=0, busy=0, done=0, all counters and shift registers 0.
REQ-034 Reset mid-load SHALL abandon the load immediately with no further cfg_en cycles.
REQ-035 Release SHALL be internally synchronised; the first active cycle SHALL be in IDLE.

Structure
REQ-036 Package retospect_pkg SHALL hold the FSM state typedef and the constants CELL_BITS=19, CLOCKBOX_BITS=48, CHAIN_LEN default.
REQ-037 Sub-module retospect_bit_packer (8-bit LSB-first deserialiser with valid/ready and flush) SHALL implement the readback path.

Verification
REQ-038 CHAIN_LEN=523, 66 bytes streamed with rd_ready=1 -> exactly 523 cfg_en cycles, 66 readback bytes, 1 done pulse.
REQ-039 Chain model preloaded with a known pattern; load 0xA5 repeated -> readback equals the preload; second load reads back 0xA5 pattern (last byte masked to 3 bits).
REQ-040 rd_ready held 0 for 20 cycles mid-load -> cfg_en=0 during the stall, no bit lost, final readback is bit-exact.
REQ-041 in_valid gaps of 5 cycles between bytes -> cfg_en is never asserted in FETCH, and the total cfg_en count is still 523.
REQ-042 abort asserted after 100 bits -> cfg_en=0 the same cycle, IDLE next cycle, no done; a restart then completes a full load.
REQ-043 rst_n pulsed low mid-SHIFT -> all outputs 0 asynchronously, and start behaves normally after release.

Source files
------------

// File: rtl/retospect_pkg.sv
// rtl/retospect_pkg.sv - shared types and constants for the configuration-chain loader
package retospect_pkg;

    localparam int BYTE_W            = 8;
    localparam int CELL_BITS         = 19;
    localparam int CLOCKBOX_BITS     = 48;
    localparam int NUM_CELLS         = 25;
    localparam int CHAIN_LEN_DEFAULT = CLOCKBOX_BITS + NUM_CELLS * CELL_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/retospect_cfg_loader_if.sv
// rtl/retospect_cfg_loader_if.sv - config byte stream in, readback byte stream out
interface retospect_cfg_loader_if;
    import retospect_pkg::*;

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  rd_data,
        input  rd_valid,
        output rd_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output rd_data,
        output rd_valid,
        input  rd_ready
    );

endinterface

// File: rtl/retospect_bit_packer.sv
// rtl/retospect_bit_packer.sv - LSB-first bit-to-byte deserialiser with hold-until-ready output and flush
module retospect_bit_packer
    import retospect_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              flush,
    output logic [BYTE_W-1:0] tdata,
    output logic              tvalid,
    input  logic              tready,
    output logic              stall,
    output logic              empty
);

    logic [BYTE_W-1:0] sreg;
    logic [2:0]        cnt;
    logic [BYTE_W-1:0] shifted;
    logic [3:0]        pad;

    // New bits enter at the top, so after k bits they sit in sreg[7:8-k].
    assign shifted = {bit_in, sreg[BYTE_W-1:1]};
    assign pad     = 4'd8 - {1'b0, cnt};
    // Holding byte still unclaimed: the eighth bit would have nowhere to go.
    assign stall   = tvalid && (cnt == 3'd7);
    assign empty   = (cnt == 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg   <= '0;
            cnt    <= '0;
            tdata  <= '0;
            tvalid <= 1'b0;
        end else if (clear) begin
            sreg   <= '0;
            cnt    <= '0;
            tdata  <= '0;
            tvalid <= 1'b0;
        end else begin
            if (tvalid && tready) begin
                tvalid <= 1'b0;
            end
            if (bit_valid) begin
                if (cnt == 3'd7) begin
                    tdata  <= shifted;
                    tvalid <= 1'b1;
                    sreg   <= '0;
                    cnt    <= '0;
                end else begin
                    sreg <= shifted;
                    cnt  <= cnt + 3'd1;
                end
            end else if (flush && !empty && !tvalid) begin
                tdata  <= sreg >> pad;
                tvalid <= 1'b1;
                sreg   <= '0;
                cnt    <= '0;
            end
        end
    end

endmodule

// File: rtl/retospect_cfg_loader.sv
// rtl/retospect_cfg_loader.sv - streams config bytes LSB-first into the chain and packs the returning bits
module retospect_cfg_loader
    import retospect_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT,
    parameter int CNT_W     = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    retospect_cfg_loader_if.slave bus,
    output logic                  cfg_en,
    output logic                  cfg_bs,
    input  logic                  cfg_ret,
    output logic                  busy,
    output logic                  done
);

    logic [1:0]        rst_sync;
    logic              rst_core_n;
    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [2:0]        byte_cnt;
    logic [BYTE_W-1:0] shreg;
    logic              rb_stall;
    logic              rb_empty;
    logic              rb_valid;
    logic [BYTE_W-1:0] rb_data;
    logic              shift_fire;
    logic              in_fire;
    logic              last_bit;
    logic              byte_end;

    // Reset asserts immediately but releases two edges later, so the core never sees a partial release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_core_n = rst_sync[1];

    assign shift_fire   = (state == ST_SHIFT) && !rb_stall && !abort;
    assign cfg_en       = shift_fire;
    assign cfg_bs       = shift_fire & shreg[0];
    assign bus.in_ready = (state == ST_FETCH) && !abort;
    assign in_fire      = bus.in_ready && bus.in_valid;
    assign last_bit     = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign byte_end     = (byte_cnt == 3'd7);
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE) && !abort;
    assign bus.rd_data  = rb_data;
    assign bus.rd_valid = rb_valid;

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
        end else if (abort) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_FETCH;
                        bit_cnt <= '0;
                    end
                end
                ST_FETCH: begin
                    if (in_fire) begin
                        shreg    <= bus.in_data;
                        byte_cnt <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Leaving on the chain-length bit also drops the unused top bits of the last byte.
                    if (shift_fire) begin
                        shreg    <= {1'b0, shreg[BYTE_W-1:1]};
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                        byte_cnt <= byte_cnt + 3'd1;
                        if (last_bit) begin
                            state <= ST_DRAIN;
                        end else if (byte_end) begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!rb_valid && rb_empty) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    retospect_bit_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_core_n),
        .clear     (abort),
        .bit_valid (shift_fire),
        .bit_in    (cfg_ret),
        .flush     (state == ST_DRAIN),
        .tdata     (rb_data),
        .tvalid    (rb_valid),
        .tready    (bus.rd_ready),
        .stall     (rb_stall),
        .empty     (rb_empty)
    );

endmodule

// File: tb/tb_retospect_cfg_loader.sv
// tb/tb_retospect_cfg_loader.sv - directed self-checking bench with a behavioural chain model
module tb_retospect_cfg_loader;

    localparam int CL = 523;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic abort;
    logic cfg_en;
    logic cfg_bs;
    logic cfg_ret;
    logic busy;
    logic done;

    retospect_cfg_loader_if bus ();

    retospect_cfg_loader #(.CHAIN_LEN(CL), .CNT_W(10)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .bus     (bus),
        .cfg_en  (cfg_en),
        .cfg_bs  (cfg_bs),
        .cfg_ret (cfg_ret),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    logic [CL-1:0]  chain;
    logic [527:0]   pre_v;
    logic           load_pre;

    always @(posedge clk) begin
        if (load_pre) begin
            chain <= pre_v[CL-1:0];
        end else if (cfg_en) begin
            chain <= {cfg_bs, chain[CL-1:1]};
        end
    end
    assign cfg_ret = chain[0];

    int         n_cmp = 0;
    int         n_bad = 0;
    int         en_cnt = 0;
    int         en_fetch = 0;
    int         done_cnt = 0;
    int         hold_cyc = 0;
    int         hold_en = 0;
    logic [7:0] rb_q[$];

    always @(negedge clk) begin
        if (cfg_en) en_cnt++;
        if (cfg_en && bus.in_ready) en_fetch++;
        if (done) done_cnt++;
        if (bus.rd_valid && bus.rd_ready) rb_q.push_back(bus.rd_data);
        if (bus.rd_valid && !bus.rd_ready) begin
            hold_cyc++;
            if (cfg_en) hold_en++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [527:0] fill_vec(input logic [7:0] f);
        logic [527:0] v;
        v = '0;
        for (int i = 0; i < CL; i++) v[i] = f[i % 8];
        return v;
    endfunction

    task automatic check_rb(input string tag, input logic [527:0] ev);
        int         bad;
        logic [7:0] e;
        bad = 0;
        check({tag, "_cnt"}, rb_q.size(), 66);
        for (int k = 0; k < rb_q.size() && k < 66; k++) begin
            e = ev[k*8 +: 8];
            if (rb_q[k] !== e) bad++;
        end
        check({tag, "_data"}, bad, 0);
    endtask

    // Called at posedge+1; returns at posedge+1 after done, after stop_bits cfg_en cycles, or on budget.
    task automatic run_load(input logic [7:0] fill, input int gap, input int stall_from,
                            input int stall_len, input int stop_bits);
        int   sent;
        int   gap_left;
        int   en0;
        logic acc;
        logic fin;
        sent = 0;
        gap_left = 0;
        en0 = en_cnt;
        rb_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            fin = done;
            @(posedge clk); #1;
            if (fin) break;
            if (stop_bits >= 0 && (en_cnt - en0) >= stop_bits) break;
            if (acc) begin
                sent++;
                bus.in_valid = 1'b0;
                gap_left = gap;
            end
            if (!bus.in_valid && sent < 66) begin
                if (gap_left == 0) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = fill;
                end else begin
                    gap_left--;
                end
            end
            bus.rd_ready = !(c >= stall_from && c < stall_from + stall_len);
        end
        bus.in_valid = 1'b0;
        bus.rd_ready = 1'b1;
    endtask

    int           en0;
    int           d0;
    int           f0;
    int           h0;
    int           he0;
    logic [527:0] e_v;
    logic [7:0]   pb;
    logic [7:0]   f5a;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.rd_ready = 1'b1;
        pre_v = '0;
        for (int i = 0; i < CL; i++) begin
            pb = 8'((i / 8) * 29 + 7);
            pre_v[i] = pb[i % 8];
        end
        load_pre = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cfg_en", cfg_en, 0);
        check("rst_cfg_bs", cfg_bs, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        load_pre = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_after_release", busy, 0);

        // Load A: preload comes back out of the chain.
        en0 = en_cnt; d0 = done_cnt; f0 = en_fetch;
        run_load(8'hA5, 0, 0, 0, -1);
        check("a_en_cycles", en_cnt - en0, 523);
        check("a_done_pulses", done_cnt - d0, 1);
        check("a_en_in_fetch", en_fetch - f0, 0);
        check_rb("a_rb", pre_v);
        check("a_idle", busy, 0);

        // Load B: 20-cycle readback stall mid-load, reads back the A5 stream.
        en0 = en_cnt; d0 = done_cnt; h0 = hold_cyc; he0 = hold_en;
        run_load(8'h3C, 0, 200, 20, -1);
        check("b_en_cycles", en_cnt - en0, 523);
        check("b_done_pulses", done_cnt - d0, 1);
        check("b_stall_seen", (hold_cyc - h0) >= 10, 1);
        check("b_stall_en_bound", (hold_en - he0) <= 7, 1);
        check_rb("b_rb", fill_vec(8'hA5));

        // Load C: 5-cycle gaps between input bytes.
        en0 = en_cnt; d0 = done_cnt; f0 = en_fetch;
        run_load(8'h5A, 5, 0, 0, -1);
        check("c_en_cycles", en_cnt - en0, 523);
        check("c_done_pulses", done_cnt - d0, 1);
        check("c_en_in_fetch", en_fetch - f0, 0);
        check_rb("c_rb", fill_vec(8'h3C));

        // Load D: abort after 100 bits.
        en0 = en_cnt; d0 = done_cnt;
        run_load(8'hFF, 0, 0, 0, 100);
        check("d_bits_before_abort", en_cnt - en0, 100);
        abort = 1'b1;
        #1;
        check("d_abort_cfg_en", cfg_en, 0);
        @(negedge clk);
        check("d_abort_busy_same_cycle", busy, 1);
        @(posedge clk); #1;
        abort = 1'b0;
        check("d_abort_idle", busy, 0);
        check("d_abort_rd_valid", bus.rd_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("d_abort_en_total", en_cnt - en0, 100);
        check("d_abort_no_done", done_cnt - d0, 0);

        // Load E: restart; chain holds 0x5A stream shifted by 100 with ones on top.
        f5a = 8'h5A;
        e_v = '0;
        for (int i = 0; i < CL; i++) e_v[i] = (i < CL - 100) ? f5a[(i + 100) % 8] : 1'b1;
        en0 = en_cnt; d0 = done_cnt;
        run_load(8'h81, 0, 0, 0, -1);
        check("e_en_cycles", en_cnt - en0, 523);
        check("e_done_pulses", done_cnt - d0, 1);
        check_rb("e_rb", e_v);

        // Load F: asynchronous reset mid-shift.
        en0 = en_cnt; d0 = done_cnt;
        run_load(8'h11, 0, 0, 0, 50);
        #2;
        rst_n = 1'b0;
        #1;
        check("f_rst_cfg_en", cfg_en, 0);
        check("f_rst_cfg_bs", cfg_bs, 0);
        check("f_rst_busy", busy, 0);
        check("f_rst_in_ready", bus.in_ready, 0);
        check("f_rst_rd_valid", bus.rd_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("f_rst_en_total", en_cnt - en0, 50);
        check("f_rst_no_done", done_cnt - d0, 0);
        check("f_rst_idle", busy, 0);

        // Load G: normal start after reset release.
        en0 = en_cnt; d0 = done_cnt;
        run_load(8'hC3, 0, 0, 0, -1);
        check("g_en_cycles", en_cnt - en0, 523);
        check("g_done_pulses", done_cnt - d0, 1);
        check("g_rb_cnt", rb_q.size(), 66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
